// File: rtl/regression_sample_sequencer.sv
// Streams the stored (x,y) sample set into the coefficient unit once per pass, then waits for coeff_done.
// Latency: start to first coeff_vld is 3 cycles; with coeff_ready held high each pass takes N_SAMPLES+1 cycles.
// Backpressure: coeff_ready=0 holds idx, so mem_addr re-reads the same address and x_bus/y_bus stay stable.
module regression_sample_sequencer #(
    parameter int N_SAMPLES = 150,
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 20,
    parameter int N_PASSES  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_x,
    input  logic [DATA_W-1:0] mem_y,
    output logic [DATA_W-1:0] x_bus,
    output logic [DATA_W-1:0] y_bus,
    output logic              coeff_vld,
    input  logic              coeff_ready,
    output logic              coeff_en,
    output logic              coeff_cout,
    input  logic              coeff_done
);

    localparam int                PASS_W    = $clog2(N_PASSES + 1);
    localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(N_SAMPLES - 1);
    localparam logic [PASS_W-1:0] LAST_PASS = PASS_W'(N_PASSES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_KICK,
        S_PRIME,
        S_STREAM,
        S_WAIT_DONE,
        S_FIN
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] idx;
    logic [PASS_W-1:0] pass;
    logic              accept;

    // Every control output is a pure decode of the state/idx flops, so none glitch on input changes.
    assign busy       = (state != S_IDLE);
    assign done       = (state == S_FIN);
    assign coeff_en   = (state == S_KICK);
    assign coeff_vld  = (state == S_STREAM);
    assign coeff_cout = coeff_vld & (idx == LAST_IDX);
    assign accept     = coeff_vld & coeff_ready;

    // Look one address ahead on accept so the next sample lands exactly one cycle later.
    assign mem_addr = (state == S_STREAM) ? idx + {{(ADDR_W-1){1'b0}}, accept} : '0;
    assign x_bus    = mem_x;
    assign y_bus    = mem_y;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
            idx   <= '0;
            pass  <= '0;
        end else if (abort) begin
            state <= S_IDLE;
            idx   <= '0;
            pass  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) state <= S_KICK;
                end
                S_KICK: begin
                    idx   <= '0;
                    pass  <= '0;
                    state <= S_PRIME;
                end
                S_PRIME: begin
                    state <= S_STREAM;
                end
                S_STREAM: begin
                    if (accept) begin
                        if (coeff_cout) begin
                            idx <= '0;
                            if (pass == LAST_PASS) begin
                                state <= S_WAIT_DONE;
                            end else begin
                                pass  <= pass + PASS_W'(1);
                                state <= S_PRIME;
                            end
                        end else begin
                            idx <= idx + ADDR_W'(1);
                        end
                    end
                end
                S_WAIT_DONE: begin
                    if (coeff_done) state <= S_FIN;
                end
                S_FIN: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
